// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mdu_state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// One-bit-per-cycle shift-add multiplier / restoring divider for the EX stage.
// Signed operands run through the unsigned loop as magnitudes; signs are fixed up in FINISH.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy,
    output logic             stall,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mdu_state_t state, next_state;

    logic [CNT_W-1:0]   count;
    logic               op_q, signed_q, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b, orig_a, rem;
    logic [2*WIDTH-1:0] acc;
    logic               load_c, step_c, finish_c, last_iter_c;

    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic [WIDTH:0]     mul_sum_c, div_shift_c;
    logic               div_ge_c;
    logic [WIDTH-1:0]   div_rem_next_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quot_c, remd_c;

    assign last_iter_c = (count == CNT_W'(WIDTH));
    assign stall       = busy | start;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_iter_c) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        unique case (state)
            IDLE:    load_c   = start;
            CALC:    step_c   = !last_iter_c;
            FINISH:  finish_c = 1'b1;
            default: ;
        endcase
    end

    mdu_sign_fix #(.W(WIDTH)) u_mag_a (
        .value (operand_a),
        .negate(signed_op & operand_a[WIDTH-1]),
        .result(mag_a_c)
    );

    mdu_sign_fix #(.W(WIDTH)) u_mag_b (
        .value (operand_b),
        .negate(signed_op & operand_b[WIDTH-1]),
        .result(mag_b_c)
    );

    // Multiply step: add multiplicand into the upper half on multiplier LSB, then shift right
    assign mul_sum_c = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a})
                              : {1'b0, acc[2*WIDTH-1:WIDTH]};

    // Divide step: W+1-bit partial remainder takes the next dividend bit from the top of acc
    assign div_shift_c    = {rem, acc[WIDTH-1]};
    assign div_ge_c       = (div_shift_c >= {1'b0, mag_b});
    assign div_rem_next_c = div_ge_c ? WIDTH'(div_shift_c - {1'b0, mag_b})
                                     : div_shift_c[WIDTH-1:0];

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value (acc),
        .negate(signed_q & (sign_a ^ sign_b)),
        .result(prod_c)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
        .value (acc[WIDTH-1:0]),
        .negate(signed_q & (sign_a ^ sign_b)),
        .result(quot_c)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value (rem),
        .negate(signed_q & sign_a),
        .result(remd_c)
    );

    // Datapath and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            op_q        <= OP_MUL;
            signed_q    <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            orig_a      <= '0;
            rem         <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish_c;
            busy <= (next_state != IDLE);
            if (load_c) begin
                op_q        <= op;
                signed_q    <= signed_op;
                sign_a      <= signed_op & operand_a[WIDTH-1];
                sign_b      <= signed_op & operand_b[WIDTH-1];
                mag_a       <= mag_a_c;
                mag_b       <= mag_b_c;
                orig_a      <= operand_a;
                count       <= '0;
                rem         <= '0;
                div_by_zero <= 1'b0;
                acc         <= (op == OP_MUL) ? {WIDTH'(0), mag_b_c} : {WIDTH'(0), mag_a_c};
            end
            if (step_c) begin
                count <= count + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc <= {mul_sum_c, acc[WIDTH-1:1]};
                end else begin
                    acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge_c};
                    rem <= div_rem_next_c;
                end
            end
            if (finish_c) begin
                if (op_q == OP_MUL) begin
                    hi <= prod_c[2*WIDTH-1:WIDTH];
                    lo <= prod_c[WIDTH-1:0];
                end else if (mag_b == '0) begin
                    hi          <= orig_a;
                    lo          <= '1;
                    div_by_zero <= 1'b1;
                end else begin
                    hi <= remd_c;
                    lo <= quot_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: per-cycle compare against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic          signed_op = 1'b0;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic [W-1:0]  hi, lo;
    logic          done, busy, stall, div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .signed_op  (signed_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hi         (hi),
        .lo         (lo),
        .done       (done),
        .busy       (busy),
        .stall      (stall),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {div_by_zero, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] ref_op(input logic o, input logic s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 1'b0) begin
            if (s) p = 64'(sa * sb);
            else   p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
        if (s) begin
            q = sa / sb;
            r = sa % sb;
            return {1'b0, 32'(r), 32'(q)};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Model state, advanced at each rising edge
    int          cyc = 0;
    int          d_edge = 0;
    int          done_edge = -1;
    bit          pending = 0;
    logic [64:0] res = '0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic        m_dbz = 1'b0;
    bit          chk_on = 0;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            pending   = 0;
            m_hi      = '0;
            m_lo      = '0;
            m_dbz     = 1'b0;
            done_edge = -1;
        end else if (pending && cyc == d_edge) begin
            m_dbz     = res[64];
            m_hi      = res[63:32];
            m_lo      = res[31:0];
            pending   = 0;
            done_edge = cyc;
        end else if (!pending && start) begin
            res     = ref_op(op, signed_op, operand_a, operand_b);
            d_edge  = cyc + LAT;
            pending = 1;
            m_dbz   = 1'b0;
        end
    end

    // Every-cycle comparison, just after the falling edge so driven inputs have settled
    always begin
        @(negedge clock);
        #1;
        if (chk_on) begin
            chk("busy", 64'(busy), 64'(pending));
            chk("done", 64'(done), 64'(done_edge == cyc));
            chk("stall", 64'(stall), 64'(pending | start));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return W'($urandom_range(0, 20));
            5:       return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a falling edge: present a request for one cycle, then scramble the operand inputs
    task automatic issue(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op        = o;
        signed_op = s;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        start     = 1'b0;
        op        = 1'($urandom);
        signed_op = 1'($urandom);
        operand_a = W'($urandom);
        operand_b = W'($urandom);
    endtask

    // Counts rising edges after the sampling edge until done; optionally pokes start at iteration spur_k
    task automatic wait_done(input int spur_k, output int k);
        k = 0;
        while (1) begin
            @(negedge clock);
            k++;
            if (start) start = 1'b0;
            if (done) return;
            if (k == spur_k) begin
                start     = 1'b1;
                op        = 1'($urandom);
                signed_op = 1'($urandom);
                operand_a = rnd_val();
                operand_b = rnd_val();
            end
            if (k > 2 * LAT) begin
                start = 1'b0;
                chk("done_timeout", 64'(k), 64'(LAT));
                return;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  saw_done;
        logic o, s;

        repeat (3) @(negedge clock);
        chk_on = 1;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_dbz", 64'(div_by_zero), 64'h0);
        reset = 1'b0;
        @(negedge clock);

        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, k);
        chk("umul_latency", 64'(k), 64'd34);
        chk("umul_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("umul_lo", 64'(lo), 64'h0000_0001);

        @(negedge clock);
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_done(0, k);
        chk("smul_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("smul_lo", 64'(lo), 64'hFFFF_FFF1);

        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, k);
        chk("sdiv_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("sdiv_hi", 64'(hi), 64'hFFFF_FFFF);

        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, k);
        chk("min_div_lo", 64'(lo), 64'h8000_0000);
        chk("min_div_hi", 64'(hi), 64'h0);

        issue(1'b1, 1'b0, 32'd100, 32'd0);
        wait_done(0, k);
        chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dbz_hi", 64'(hi), 64'h0000_0064);
        chk("dbz_flag", 64'(div_by_zero), 64'h1);

        @(negedge clock);
        issue(1'b0, 1'b0, 32'd12345, 32'd678);
        wait_done(5, k);
        chk("ignored_start_latency", 64'(k), 64'd34);
        chk("ignored_start_lo", 64'(lo), 64'h007F_B6F6);
        chk("ignored_start_hi", 64'(hi), 64'h0);
        chk("dbz_cleared", 64'(div_by_zero), 64'h0);

        @(negedge clock);
        issue(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        saw_done = 0;
        repeat (LAT + 6) begin
            @(negedge clock);
            if (done) saw_done = 1;
        end
        chk("rst_no_done", 64'(saw_done), 64'h0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
            o = 1'($urandom);
            s = 1'($urandom);
            issue(o, s, rnd_val(), rnd_val());
            wait_done(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0, k);
            chk("rand_latency", 64'(k), 64'(LAT));
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
